// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and derived totals, used by the sync
// generator and by whatever produces pixel data against the same raster.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;

    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_TICK_DIV  = 4;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic int span_total(input int display, input int front,
                                      input int sync, input int back);
        return display + front + sync + back;
    endfunction

    localparam int VGA_H_TOTAL = span_total(VGA_H_DISPLAY, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
    localparam int VGA_V_TOTAL = span_total(VGA_V_DISPLAY, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to the pixel rate: a mod-TICK_DIV counter
// whose registered p_tick is high on the last count of each pixel period.
module pixel_tick_gen
    import vga_timing_pkg::*;
#(
    parameter int TICK_DIV = VGA_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    output logic p_tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
    end

    // p_tick is decoded from div_next so it tracks the count with no lag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div    <= '0;
            p_tick <= 1'b0;
        end else begin
            div    <= div_next;
            p_tick <= (div_next == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel/line counters stepped by the pixel tick, with
// sync, blanking and frame-start outputs registered in step with the counts.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter int TICK_DIV  = VGA_TICK_DIV
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start
);

    localparam int H_TOTAL = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam coord_t H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam coord_t V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam coord_t H_VIS    = COORD_W'(H_DISPLAY);
    localparam coord_t V_VIS    = COORD_W'(V_DISPLAY);
    localparam coord_t HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    coord_t x_next;
    coord_t y_next;
    logic   line_end;
    logic   frame_wrap;

    pixel_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .p_tick (p_tick)
    );

    always_comb begin
        line_end   = p_tick && (pixel_x == H_LAST);
        frame_wrap = line_end && (pixel_y == V_LAST);
        x_next     = pixel_x;
        y_next     = pixel_y;
        if (p_tick) begin
            x_next = line_end ? '0 : pixel_x + 1'b1;
        end
        if (line_end) begin
            y_next = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
        end
    end

    // Decoding from the next counts keeps sync/blank aligned with pixel_x/pixel_y
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_next;
            pixel_y     <= y_next;
            hsync       <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vsync       <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            video_on    <= (x_next < H_VIS) && (y_next < V_VIS);
            frame_start <= frame_wrap;
        end
    end

endmodule
